sobel_window_gen: RTL and testbench



---
 rtl/sobel_pkg.sv | 22 ++
 rtl/line_buffer.sv | 24 ++
 rtl/sobel_window_gen.sv | 112 +++++++++++
 tb/tb_sobel_window_gen.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sobel_pkg.sv
// Shared constants for the Sobel edge path.
// Default pixel width, 3x3 window slot indices and the slot helper.
package sobel_pkg;

  localparam int SOBEL_DW = 8;

  localparam int W00 = 0;
  localparam int W01 = 1;
  localparam int W02 = 2;
  localparam int W10 = 3;
  localparam int W11 = 4;
  localparam int W12 = 5;
  localparam int W20 = 6;
  localparam int W21 = 7;
  localparam int W22 = 8;

  // Row i (0 = oldest), column j (0 = leftmost).
  function automatic int win_idx(input int i, input int j);
    return 3 * i + j;
  endfunction

endpackage

// File: rtl/line_buffer.sv
// Read-before-write line store, one entry per column.
// Ports: clk_i, en_i (write), addr_i, wdata_i, rdata_o (old contents).
module line_buffer #(
  parameter int DEPTH = 64,
  parameter int WIDTH = 8
) (
  input  logic                     clk_i,
  input  logic                     en_i,
  input  logic [$clog2(DEPTH)-1:0] addr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  assign rdata_o = mem_q[addr_i];

  always_ff @(posedge clk_i) begin
    if (en_i) begin
      mem_q[addr_i] <= wdata_i;
    end
  end

endmodule

// File: rtl/sobel_window_gen.sv
// Raster pixel stream to registered 3x3 interior windows for Sobel.
// Ports: clk, rst_n, frame_start, pix_valid, pix_in -> win, win_valid,
// win_row, win_col, frame_done.
module sobel_window_gen
  import sobel_pkg::*;
#(
  parameter int IMG_W = 64,
  parameter int IMG_H = 64,
  parameter int DW    = SOBEL_DW
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     frame_start,
  input  logic                     pix_valid,
  input  logic [DW-1:0]            pix_in,
  output logic [9*DW-1:0]          win,
  output logic                     win_valid,
  output logic [$clog2(IMG_H)-1:0] win_row,
  output logic [$clog2(IMG_W)-1:0] win_col,
  output logic                     frame_done
);

  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);

  logic [CW-1:0]   col_q, col_d, col_e;
  logic [RW-1:0]   row_q, row_d, row_e;
  logic [9*DW-1:0] wnd_q, wnd_d, wnd_sh;
  logic [9*DW-1:0] win_d;
  logic [RW-1:0]   win_row_d;
  logic [CW-1:0]   win_col_d;
  logic            win_valid_d;
  logic            frame_done_d;
  logic            interior;
  logic            last_pix;
  logic [2*DW-1:0] lb_rd;

  // Effective position: a frame_start makes this cycle's pixel (0,0).
  assign col_e = frame_start ? '0 : col_q;
  assign row_e = frame_start ? '0 : row_q;

  // Packed {lb1, lb0}: lb1 inherits the old lb0 entry.
  line_buffer #(
    .DEPTH (IMG_W),
    .WIDTH (2 * DW)
  ) u_lb (
    .clk_i   (clk),
    .en_i    (pix_valid),
    .addr_i  (col_e),
    .wdata_i ({lb_rd[DW-1:0], pix_in}),
    .rdata_o (lb_rd)
  );

  for (genvar i = 0; i < 3; i++) begin : g_row
    assign wnd_sh[DW*win_idx(i, 0) +: DW] = wnd_q[DW*win_idx(i, 1) +: DW];
    assign wnd_sh[DW*win_idx(i, 1) +: DW] = wnd_q[DW*win_idx(i, 2) +: DW];
  end
  assign wnd_sh[DW*W02 +: DW] = lb_rd[DW +: DW];
  assign wnd_sh[DW*W12 +: DW] = lb_rd[DW-1:0];
  assign wnd_sh[DW*W22 +: DW] = pix_in;

  assign interior = pix_valid && (row_e >= RW'(2)) && (col_e >= CW'(2));
  assign last_pix = (row_e == RW'(IMG_H - 1)) && (col_e == CW'(IMG_W - 1));

  always_comb begin
    col_d        = col_e;
    row_d        = row_e;
    wnd_d        = wnd_q;
    win_d        = win;
    win_row_d    = win_row;
    win_col_d    = win_col;
    win_valid_d  = interior;
    frame_done_d = pix_valid && last_pix;
    if (pix_valid) begin
      wnd_d = wnd_sh;
      if (col_e == CW'(IMG_W - 1)) begin
        col_d = '0;
        row_d = (row_e == RW'(IMG_H - 1)) ? '0 : row_e + RW'(1);
      end else begin
        col_d = col_e + CW'(1);
      end
    end
    if (interior) begin
      win_d     = wnd_sh;
      win_row_d = row_e - RW'(1);
      win_col_d = col_e - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      col_q      <= '0;
      row_q      <= '0;
      wnd_q      <= '0;
      win        <= '0;
      win_valid  <= 1'b0;
      win_row    <= '0;
      win_col    <= '0;
      frame_done <= 1'b0;
    end else begin
      col_q      <= col_d;
      row_q      <= row_d;
      wnd_q      <= wnd_d;
      win        <= win_d;
      win_valid  <= win_valid_d;
      win_row    <= win_row_d;
      win_col    <= win_col_d;
      frame_done <= frame_done_d;
    end
  end

endmodule

// File: tb/tb_sobel_window_gen.sv
// Bench for sobel_window_gen: 4x4 and 5x3 instances against an
// image-array reference that cuts windows straight out of the frame.
module tb_sobel_window_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        fs_a, pv_a, fs_b, pv_b;
  logic [7:0]  px_a, px_b;
  logic [71:0] win_a, win_b;
  logic        wv_a, wv_b, fd_a, fd_b;
  logic [1:0]  wr_a, wc_a, wr_b;
  logic [2:0]  wc_b;

  sobel_window_gen #(.IMG_W(4), .IMG_H(4), .DW(8)) u_a (
    .clk(clk), .rst_n(rst_n), .frame_start(fs_a), .pix_valid(pv_a),
    .pix_in(px_a), .win(win_a), .win_valid(wv_a), .win_row(wr_a),
    .win_col(wc_a), .frame_done(fd_a)
  );

  sobel_window_gen #(.IMG_W(5), .IMG_H(3), .DW(8)) u_b (
    .clk(clk), .rst_n(rst_n), .frame_start(fs_b), .pix_valid(pv_b),
    .pix_in(px_b), .win(win_b), .win_valid(wv_b), .win_row(wr_b),
    .win_col(wc_b), .frame_done(fd_b)
  );

  typedef struct {
    int          cyc;
    logic [71:0] w;
    int          row;
    int          col;
  } rec_t;

  rec_t exp_q[$], got_q[$], ref_q[$];
  int   exp_fd[$], got_fd[$];
  int   cyc;
  int   n_chk, n_fail;
  logic [7:0] img [2][8][8];
  int   mr[2], mc[2];

  task automatic clear_obs();
    exp_q.delete();
    got_q.delete();
    exp_fd.delete();
    got_fd.delete();
  endtask

  // One clock of stimulus on instance d; the reference records what
  // must appear after this edge, the observed outputs are logged.
  task automatic step(input int d, input bit fs, input bit pv,
                      input logic [7:0] px);
    int   w = (d == 0) ? 4 : 5;
    int   h = (d == 0) ? 4 : 3;
    rec_t e;
    if (d == 0) begin
      fs_a = fs; pv_a = pv; px_a = px;
    end else begin
      fs_b = fs; pv_b = pv; px_b = px;
    end
    if (fs) begin
      mr[d] = 0;
      mc[d] = 0;
    end
    if (pv) begin
      img[d][mr[d]][mc[d]] = px;
      if (mr[d] >= 2 && mc[d] >= 2) begin
        e.cyc = cyc;
        e.row = mr[d] - 1;
        e.col = mc[d] - 1;
        e.w   = '0;
        for (int i = 0; i < 3; i++)
          for (int j = 0; j < 3; j++)
            e.w[8*(3*i+j) +: 8] = img[d][mr[d]-2+i][mc[d]-2+j];
        exp_q.push_back(e);
      end
      if (mr[d] == h - 1 && mc[d] == w - 1) exp_fd.push_back(cyc);
      mc[d]++;
      if (mc[d] == w) begin
        mc[d] = 0;
        mr[d]++;
        if (mr[d] == h) mr[d] = 0;
      end
    end
    @(posedge clk);
    #1;
    if (d == 0) begin
      if (wv_a) begin
        e.cyc = cyc; e.w = win_a; e.row = int'(wr_a); e.col = int'(wc_a);
        got_q.push_back(e);
      end
      if (fd_a) got_fd.push_back(cyc);
      fs_a = 0; pv_a = 0;
    end else begin
      if (wv_b) begin
        e.cyc = cyc; e.w = win_b; e.row = int'(wr_b); e.col = int'(wc_b);
        got_q.push_back(e);
      end
      if (fd_b) got_fd.push_back(cyc);
      fs_b = 0; pv_b = 0;
    end
    cyc++;
  endtask

  task automatic test_reset();
    rst_n = 0;
    fs_a = 0; pv_a = 0; px_a = 0;
    fs_b = 0; pv_b = 0; px_b = 0;
    repeat (3) @(posedge clk);
    #1;
    n_chk += 10;
    if (win_a !== '0) begin n_fail++; $display("FAIL rst_win_a got %h want 0", win_a); end
    if (wv_a !== 1'b0) begin n_fail++; $display("FAIL rst_valid_a got %b want 0", wv_a); end
    if (wr_a !== '0) begin n_fail++; $display("FAIL rst_row_a got %0d want 0", wr_a); end
    if (wc_a !== '0) begin n_fail++; $display("FAIL rst_col_a got %0d want 0", wc_a); end
    if (fd_a !== 1'b0) begin n_fail++; $display("FAIL rst_done_a got %b want 0", fd_a); end
    if (win_b !== '0) begin n_fail++; $display("FAIL rst_win_b got %h want 0", win_b); end
    if (wv_b !== 1'b0) begin n_fail++; $display("FAIL rst_valid_b got %b want 0", wv_b); end
    if (wr_b !== '0) begin n_fail++; $display("FAIL rst_row_b got %0d want 0", wr_b); end
    if (wc_b !== '0) begin n_fail++; $display("FAIL rst_col_b got %0d want 0", wc_b); end
    if (fd_b !== 1'b0) begin n_fail++; $display("FAIL rst_done_b got %b want 0", fd_b); end
    @(negedge clk);
    rst_n = 1;
    mr = '{0, 0};
    mc = '{0, 0};
    @(posedge clk);
    #1;
  endtask

  task automatic test_stream();
    int c0;
    clear_obs();
    c0 = cyc;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        step(0, 0, 1, 8'(16 * r + c));
    step(0, 0, 0, 8'h00);
    n_chk++;
    if (got_q.size() != 4) begin
      n_fail++;
      $display("FAIL stream_count got %0d want 4", got_q.size());
    end
    if (got_q.size() > 0) begin
      n_chk += 6;
      if (got_q[0].cyc != c0 + 10) begin n_fail++; $display("FAIL stream_first_cyc got %0d want %0d", got_q[0].cyc, c0 + 10); end
      if (got_q[0].row != 1) begin n_fail++; $display("FAIL stream_first_row got %0d want 1", got_q[0].row); end
      if (got_q[0].col != 1) begin n_fail++; $display("FAIL stream_first_col got %0d want 1", got_q[0].col); end
      if (got_q[0].w[7:0] !== 8'h00) begin n_fail++; $display("FAIL stream_w00 got %h want 00", got_q[0].w[7:0]); end
      if (got_q[0].w[39:32] !== 8'h11) begin n_fail++; $display("FAIL stream_w11 got %h want 11", got_q[0].w[39:32]); end
      if (got_q[0].w[71:64] !== 8'h22) begin n_fail++; $display("FAIL stream_w22 got %h want 22", got_q[0].w[71:64]); end
      n_chk += 2;
      if (got_q[$].w[39:32] !== 8'h22) begin n_fail++; $display("FAIL stream_last_w11 got %h want 22", got_q[$].w[39:32]); end
      if (got_q[$].w[71:64] !== 8'h33) begin n_fail++; $display("FAIL stream_last_w22 got %h want 33", got_q[$].w[71:64]); end
    end
    n_chk++;
    if (got_fd.size() != 1) begin
      n_fail++;
      $display("FAIL stream_done_count got %0d want 1", got_fd.size());
    end else if (got_q.size() > 0) begin
      n_chk++;
      if (got_fd[0] != got_q[$].cyc) begin n_fail++; $display("FAIL stream_done_cyc got %0d want %0d", got_fd[0], got_q[$].cyc); end
    end
    for (int k = 0; k < exp_q.size() && k < got_q.size(); k++) begin
      n_chk++;
      if (got_q[k] != exp_q[k]) begin
        n_fail++;
        $display("FAIL stream_win%0d got c=%0d r=%0d c=%0d w=%h want c=%0d r=%0d c=%0d w=%h", k,
                 got_q[k].cyc, got_q[k].row, got_q[k].col, got_q[k].w,
                 exp_q[k].cyc, exp_q[k].row, exp_q[k].col, exp_q[k].w);
      end
    end
    ref_q = got_q;
  endtask

  task automatic test_stall();
    int n = 0;
    int k = 0;
    bit pv;
    clear_obs();
    while (n < 16 && k < 200) begin
      pv = (k % 5 == 3) ? 1'b0 : ($urandom_range(0, 3) != 0);
      if (pv) begin
        step(0, 0, 1, 8'(16 * (n / 4) + n % 4));
        n++;
      end else begin
        step(0, 0, 0, 8'($urandom));
      end
      k++;
    end
    step(0, 0, 0, 8'h00);
    n_chk++;
    if (got_q.size() != exp_q.size() || got_q.size() != 4) begin
      n_fail++;
      $display("FAIL stall_count got %0d want %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] != exp_q[i]) begin
        n_fail++;
        $display("FAIL stall_win%0d got c=%0d w=%h want c=%0d w=%h", i,
                 got_q[i].cyc, got_q[i].w, exp_q[i].cyc, exp_q[i].w);
      end
    end
    for (int i = 0; i < ref_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i].w !== ref_q[i].w || got_q[i].row != ref_q[i].row || got_q[i].col != ref_q[i].col) begin
        n_fail++;
        $display("FAIL stall_vs_stream%0d got w=%h want w=%h", i, got_q[i].w, ref_q[i].w);
      end
    end
    n_chk++;
    if (got_fd != exp_fd) begin n_fail++; $display("FAIL stall_done got %0d pulses want %0d", got_fd.size(), exp_fd.size()); end
  endtask

  task automatic test_back_to_back();
    logic [7:0] b;
    clear_obs();
    for (int f = 0; f < 2; f++)
      for (int r = 0; r < 4; r++)
        for (int c = 0; c < 4; c++)
          step(0, 0, 1, 8'(128 * f + 16 * r + c));
    step(0, 0, 0, 8'h00);
    n_chk++;
    if (got_q.size() != 8) begin
      n_fail++;
      $display("FAIL b2b_count got %0d want 8", got_q.size());
    end else begin
      n_chk++;
      if (got_q[4].w[7:0] !== 8'h80) begin n_fail++; $display("FAIL b2b_w00 got %h want 80", got_q[4].w[7:0]); end
      for (int i = 4; i < 8; i++)
        for (int s = 0; s < 9; s++) begin
          b = got_q[i].w[8*s +: 8];
          n_chk++;
          if (b[7] !== 1'b1) begin n_fail++; $display("FAIL b2b_stale win%0d slot%0d got %h want >=80", i, s, b); end
        end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] != exp_q[i]) begin
        n_fail++;
        $display("FAIL b2b_win%0d got c=%0d w=%h want c=%0d w=%h", i,
                 got_q[i].cyc, got_q[i].w, exp_q[i].cyc, exp_q[i].w);
      end
    end
    n_chk++;
    if (got_fd != exp_fd) begin n_fail++; $display("FAIL b2b_done got %0d pulses want %0d", got_fd.size(), exp_fd.size()); end
  endtask

  task automatic test_reset_mid();
    clear_obs();
    for (int n = 0; n < 9; n++) step(0, 0, 1, 8'(16 * (n / 4) + n % 4));
    rst_n = 0;
    #1;
    n_chk += 5;
    if (win_a !== '0) begin n_fail++; $display("FAIL midrst_win got %h want 0", win_a); end
    if (wv_a !== 1'b0) begin n_fail++; $display("FAIL midrst_valid got %b want 0", wv_a); end
    if (wr_a !== '0) begin n_fail++; $display("FAIL midrst_row got %0d want 0", wr_a); end
    if (wc_a !== '0) begin n_fail++; $display("FAIL midrst_col got %0d want 0", wc_a); end
    if (fd_a !== 1'b0) begin n_fail++; $display("FAIL midrst_done got %b want 0", fd_a); end
    @(negedge clk);
    rst_n = 1;
    mr[0] = 0;
    mc[0] = 0;
    @(posedge clk);
    #1;
    clear_obs();
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        step(0, 0, 1, 8'(16 * r + c));
    step(0, 0, 0, 8'h00);
    n_chk++;
    if (got_q.size() != ref_q.size()) begin n_fail++; $display("FAIL midrst_count got %0d want %0d", got_q.size(), ref_q.size()); end
    for (int i = 0; i < ref_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i].w !== ref_q[i].w || got_q[i].row != ref_q[i].row || got_q[i].col != ref_q[i].col) begin
        n_fail++;
        $display("FAIL midrst_win%0d got w=%h want w=%h", i, got_q[i].w, ref_q[i].w);
      end
    end
  endtask

  task automatic test_frame_start();
    int c0;
    clear_obs();
    for (int n = 0; n < 5; n++) step(0, 0, 1, 8'(16 * (n / 4) + n % 4));
    c0 = cyc;
    step(0, 1, 1, 8'h00);
    for (int n = 1; n < 16; n++) step(0, 0, 1, 8'(16 * (n / 4) + n % 4));
    step(0, 0, 0, 8'h00);
    n_chk++;
    if (got_q.size() != 4) begin
      n_fail++;
      $display("FAIL fs_count got %0d want 4", got_q.size());
    end else begin
      n_chk++;
      if (got_q[0].cyc != c0 + 10) begin n_fail++; $display("FAIL fs_first_cyc got %0d want %0d", got_q[0].cyc, c0 + 10); end
    end
    for (int i = 0; i < ref_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i].w !== ref_q[i].w || got_q[i].row != ref_q[i].row || got_q[i].col != ref_q[i].col) begin
        n_fail++;
        $display("FAIL fs_win%0d got w=%h want w=%h", i, got_q[i].w, ref_q[i].w);
      end
    end
    n_chk++;
    if (got_fd != exp_fd) begin n_fail++; $display("FAIL fs_done got %0d pulses want %0d", got_fd.size(), exp_fd.size()); end
  endtask

  task automatic test_small();
    clear_obs();
    for (int r = 0; r < 3; r++)
      for (int c = 0; c < 5; c++)
        step(1, 0, 1, 8'(16 * r + c));
    step(1, 0, 0, 8'h00);
    n_chk++;
    if (got_q.size() != 3) begin n_fail++; $display("FAIL small_count got %0d want 3", got_q.size()); end
    for (int i = 0; i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i].row != 1 || got_q[i].col != i + 1) begin
        n_fail++;
        $display("FAIL small_pos%0d got r=%0d c=%0d want r=1 c=%0d", i, got_q[i].row, got_q[i].col, i + 1);
      end
    end
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      n_chk++;
      if (got_q[i] != exp_q[i]) begin
        n_fail++;
        $display("FAIL small_win%0d got c=%0d w=%h want c=%0d w=%h", i,
                 got_q[i].cyc, got_q[i].w, exp_q[i].cyc, exp_q[i].w);
      end
    end
    n_chk++;
    if (got_fd != exp_fd) begin n_fail++; $display("FAIL small_done got %0d pulses want %0d", got_fd.size(), exp_fd.size()); end
  endtask

  initial begin
    n_chk  = 0;
    n_fail = 0;
    cyc    = 0;
    test_reset();
    test_stream();
    test_stall();
    test_back_to_back();
    test_reset_mid();
    test_frame_start();
    test_small();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
